// File: rtl/uart_tx_cfg_if.sv
// Host-side transmit handshake bundle for uart_tx_cfg: word/break requests in, line and status out.
interface uart_tx_cfg_if #(
  parameter int MAX_DATA_BITS = 9
);
  logic                     tx_valid;
  logic [MAX_DATA_BITS-1:0] tx_data;
  logic                     tx_break;
  logic                     tx_ready;
  logic                     tx_serial;
  logic                     tx_busy;
  logic                     tx_done;

  modport master (
    output tx_valid, tx_data, tx_break,
    input  tx_ready, tx_serial, tx_busy, tx_done
  );

  modport slave (
    input  tx_valid, tx_data, tx_break,
    output tx_ready, tx_serial, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (divisor, 5..MAX_DATA_BITS data, parity, 1/2 stop, break).
// Optional macro UART_TX_CTS_EN adds a synchronised active-low cts_n input that gates tx_ready.
module uart_tx_cfg #(
  parameter int MAX_DATA_BITS = 9,
  parameter int DIV_WIDTH     = 16,
  parameter int DEFAULT_DIV   = 433
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] cfg_baud_div,
  input  logic [3:0]           cfg_data_bits,
  input  logic [2:0]           cfg_parity,
  input  logic                 cfg_stop2,
`ifdef UART_TX_CTS_EN
  input  logic                 cts_n,
`endif
  uart_tx_cfg_if.slave         tx
);

  if (MAX_DATA_BITS < 5 || MAX_DATA_BITS > 9 || DEFAULT_DIV < 0) begin : g_bad_param
    $error("uart_tx_cfg: MAX_DATA_BITS must be 5..9");
  end

  localparam logic [3:0] MAXB = 4'(MAX_DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                   state_q, state_n;
  logic [DIV_WIDTH-1:0]     cnt_q, cnt_n;
  logic [3:0]               idx_q, idx_n;
  logic                     serial_q, serial_n;
  logic                     done_q, done_n;

  logic [DIV_WIDTH-1:0]     div_q;
  logic [3:0]               nbits_q;
  logic [MAX_DATA_BITS-1:0] frame_q;
  logic                     par_en_q, par_bit_q, stop2_q;

  logic [3:0]               nbits_cfg;
  logic [MAX_DATA_BITS-1:0] used;
  logic                     par_en_cfg, par_bit_cfg;
  logic [15:0]              frame_ext;
  logic                     cts_sync, accept, bit_end;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_ff;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cts_ff <= 2'b11;
    else     cts_ff <= {cts_ff[0], cts_n};
  end
  assign cts_sync = cts_ff[1];
`else
  assign cts_sync = 1'b0;
`endif

  assign tx.tx_ready  = (state_q == S_IDLE) && !tx.tx_break && !cts_sync;
  assign tx.tx_serial = serial_q;
  assign tx.tx_busy   = (state_q != S_IDLE);
  assign tx.tx_done   = done_q;

  assign accept    = tx.tx_valid && tx.tx_ready;
  assign bit_end   = (cnt_q == div_q);
  assign frame_ext = 16'(frame_q);

  // Frame configuration decode: clamp width, mask unused bits, resolve parity
  always_comb begin
    if (cfg_data_bits < 4'd5)       nbits_cfg = 4'd5;
    else if (cfg_data_bits > MAXB)  nbits_cfg = MAXB;
    else                            nbits_cfg = cfg_data_bits;
    used = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++)
      used[i] = tx.tx_data[i] & (i < int'(nbits_cfg));
    par_en_cfg  = 1'b1;
    par_bit_cfg = 1'b0;
    case (cfg_parity)
      3'd1:    par_bit_cfg = ^used;
      3'd2:    par_bit_cfg = ~(^used);
      3'd3:    par_bit_cfg = 1'b1;
      3'd4:    par_bit_cfg = 1'b0;
      default: par_en_cfg  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      div_q     <= cfg_baud_div;
      nbits_q   <= nbits_cfg;
      frame_q   <= tx.tx_data;
      par_en_q  <= par_en_cfg;
      par_bit_q <= par_bit_cfg;
      stop2_q   <= cfg_stop2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      idx_q    <= idx_n;
      serial_q <= serial_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    done_n  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx.tx_break) begin
          state_n = S_BREAK;
        end else if (accept) begin
          state_n = S_START;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      S_START, S_DATA, S_PARITY, S_STOP: begin
        cnt_n = bit_end ? '0 : cnt_q + DIV_WIDTH'(1);
        if (bit_end) begin
          case (state_q)
            S_START: begin
              state_n = S_DATA;
              idx_n   = '0;
            end
            S_DATA: begin
              if (idx_q == nbits_q - 4'd1) begin
                idx_n   = '0;
                state_n = par_en_q ? S_PARITY : S_STOP;
              end else begin
                idx_n = idx_q + 4'd1;
              end
            end
            S_PARITY: begin
              state_n = S_STOP;
              idx_n   = '0;
            end
            default: idx_n = idx_q + 4'd1;
          endcase
        end
      end
      S_BREAK: if (!tx.tx_break) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // The final clock of the last stop bit is spent in IDLE so a new accept can land on the frame boundary
    if (state_n == S_STOP && idx_n == {3'b000, stop2_q} && cnt_n == div_q) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      idx_n   = '0;
      done_n  = 1'b1;
    end
    case (state_n)
      S_START, S_BREAK: serial_n = 1'b0;
      S_DATA:           serial_n = frame_ext[idx_n];
      S_PARITY:         serial_n = par_bit_q;
      default:          serial_n = 1'b1;
    endcase
  end

endmodule
